// File: rtl/edge_pulse_sync_n.sv
// edge_pulse_sync_n: per-channel pad conditioner.
// Performs synchronising, glitch filtering and edge-pulse generation.
// Ports:
//   clk    system clock
//   nRst   asynchronous active-low reset
//   i      raw asynchronous inputs, one bit per channel
//   mode   edge select for q: 00 none, 01 rise, 10 fall, 11 both
//   level  filtered, synchronised level
//   rise   one-cycle pulse on each filtered 0->1 transition
//   fall   one-cycle pulse on each filtered 1->0 transition
//   q      one-cycle event pulse, selected by mode
module edge_pulse_sync_n #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 1
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] q
);

  localparam int CW = $clog2(FILT_CNT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CNT - 1);

  logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_d;
  logic [WIDTH-1:0][CW-1:0]          cnt_q;
  logic [WIDTH-1:0][CW-1:0]          cnt_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    sync_d  = sync_q;
    cnt_d   = '0;
    level_d = level_q;
    s       = '0;
    for (int n = 0; n < WIDTH; n++) begin
      sync_d[n] = {sync_q[n][SYNC_STAGES-2:0], i[n]};
      s[n]      = sync_q[n][SYNC_STAGES-1];
      // Any cycle with s==level drops the count back to zero,
      // so short deviations never add up.
      if (s[n] != level_q[n]) begin
        if (cnt_q[n] == CNT_MAX) begin
          level_d[n] = s[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
    q_d    = ({WIDTH{mode[0]}} & rise_d)
           | ({WIDTH{mode[1]}} & fall_d);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      q_q     <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      q_q     <= q_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign q     = q_q;

endmodule

// File: tb/tb_edge_pulse_sync_n.sv
// tb_edge_pulse_sync_n: directed bench for edge_pulse_sync_n.
// Three instances cover default, filtered and wide/deep-sync setups.
module tb_edge_pulse_sync_n;

  logic clk = 1'b0;
  logic nRst = 1'b0;

  logic       i_a;
  logic [1:0] mode_a;
  logic       level_a, rise_a, fall_a, q_a;

  logic       i_b;
  logic [1:0] mode_b;
  logic       level_b, rise_b, fall_b, q_b;

  logic [3:0] i_c;
  logic [1:0] mode_c;
  logic [3:0] level_c, rise_c, fall_c, q_c;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  edge_pulse_sync_n u_a (
    .clk(clk), .nRst(nRst), .i(i_a), .mode(mode_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .q(q_a)
  );

  edge_pulse_sync_n #(.FILT_CNT(4)) u_b (
    .clk(clk), .nRst(nRst), .i(i_b), .mode(mode_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .q(q_b)
  );

  edge_pulse_sync_n #(.WIDTH(4), .SYNC_STAGES(3)) u_c (
    .clk(clk), .nRst(nRst), .i(i_c), .mode(mode_c),
    .level(level_c), .rise(rise_c), .fall(fall_c), .q(q_c)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] act;
  int          r_n, f_n, q_n, r_at, f_at;
  int          ra_n, ra_at, rb_n, rb_at;

  initial begin
    i_a = 0; i_b = 0; i_c = '0;
    mode_a = 2'b01; mode_b = 2'b11; mode_c = 2'b10;
    step(); step();
    chk("rst a", {level_a, rise_a, fall_a, q_a}, 0);
    chk("rst b", {level_b, rise_b, fall_b, q_b}, 0);
    chk("rst c", {level_c, rise_c, fall_c, q_c}, 0);
    nRst = 1;
    step(); step();

    // t1: default params, rise then fall
    i_a = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t1 rise lvl k%0d", k), level_a, k >= 3);
      chk($sformatf("t1 rise r k%0d", k), rise_a, k == 3);
      chk($sformatf("t1 rise q k%0d", k), q_a, k == 3);
      chk($sformatf("t1 rise f k%0d", k), fall_a, 0);
    end
    i_a = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t1 fall lvl k%0d", k), level_a, k < 3);
      chk($sformatf("t1 fall f k%0d", k), fall_a, k == 3);
      chk($sformatf("t1 fall q k%0d", k), q_a, 0);
    end

    // t2: 3-cycle glitch rejected
    act = 0;
    i_b = 1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) i_b = 0;
      step();
      act |= {level_b, rise_b, fall_b, q_b};
    end
    chk("t2 glitch", act, 0);

    // t2: 4-cycle pulse qualifies
    r_n = 0; f_n = 0; q_n = 0; r_at = 0; f_at = 0;
    i_b = 1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) i_b = 0;
      step();
      if (rise_b) begin r_n++; r_at = k; end
      if (fall_b) begin f_n++; f_at = k; end
      if (q_b) q_n++;
      if (rise_b && fall_b) chk("t2 r&f", 1, 0);
      if (k == 8) chk("t2 lvl mid", level_b, 1);
    end
    chk("t2 rise n", r_n, 1);
    chk("t2 rise at", r_at, 6);
    chk("t2 fall n", f_n, 1);
    chk("t2 fall at", f_at, 10);
    chk("t2 q n", q_n, 2);
    chk("t2 lvl end", level_b, 0);

    // t3: 3 high / 1 low never accumulates
    act = 0;
    for (int k = 0; k < 40; k++) begin
      i_b = (k % 4) != 3;
      step();
      act |= {level_b, rise_b, fall_b, q_b};
    end
    i_b = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      act |= {level_b, rise_b, fall_b, q_b};
    end
    chk("t3 no change", act, 0);

    // t4: wide, 3-stage sync, fall-only q
    act = 0;
    i_c = 4'b1010;
    for (int k = 1; k <= 6; k++) begin
      step();
      act |= q_c;
      if (k == 3) chk("t4a rise k3", rise_c, 0);
      if (k == 4) chk("t4a rise k4", rise_c, 4'b1010);
      if (k == 5) chk("t4a rise k5", rise_c, 0);
    end
    chk("t4a q none", act, 0);
    chk("t4a lvl", level_c, 4'b1010);
    i_c = 4'b0110;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) chk("t4b fall k3", fall_c, 0);
      if (k == 4) begin
        chk("t4b fall k4", fall_c, 4'b1000);
        chk("t4b rise k4", rise_c, 4'b0100);
        chk("t4b q k4", q_c, 4'b1000);
        chk("t4b lvl k4", level_c, 4'b0110);
      end
      if (k == 5) chk("t4b q k5", q_c, 0);
    end

    // t5: input high through reset
    i_a = 1; i_b = 1;
    nRst = 0;
    step(); step();
    chk("t5 in rst", {level_a, level_b}, 0);
    nRst = 1;
    ra_n = 0; ra_at = 0; rb_n = 0; rb_at = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (rise_a) begin ra_n++; ra_at = k; end
      if (rise_b) begin rb_n++; rb_at = k; end
    end
    chk("t5 a n", ra_n, 1);
    chk("t5 a at", ra_at, 3);
    chk("t5 b n", rb_n, 1);
    chk("t5 b at", rb_at, 6);
    chk("t5 lvl", {level_a, level_b}, 2'b11);

    // t6: reset during active pulse and partial count
    i_a = 0; i_b = 0;
    for (int k = 0; k < 8; k++) step();
    chk("t6 pre lvl", {level_a, level_b}, 0);
    i_a = 1; i_b = 1;
    step(); step(); step();
    chk("t6 pre rise", rise_a, 1);
    #1 nRst = 0;
    #1;
    chk("t6 rst a", {level_a, rise_a, fall_a, q_a}, 0);
    chk("t6 rst b", {level_b, rise_b, fall_b, q_b}, 0);
    step();
    nRst = 1;
    ra_n = 0; ra_at = 0; rb_n = 0; rb_at = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rise_a) begin ra_n++; ra_at = k; end
      if (rise_b) begin rb_n++; rb_at = k; end
    end
    chk("t6 a n", ra_n, 1);
    chk("t6 a at", ra_at, 3);
    chk("t6 b n", rb_n, 1);
    chk("t6 b at", rb_at, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
